// File: rtl/gac_mem_initiator_if.sv
// gac_mem_initiator_if
//   Bundles the three bus groups used by the RAM request initiator:
//     req_*  pipeline -> initiator request channel (valid/ready)
//     rsp_*  initiator -> pipeline response channel (valid/ready)
//     ram_*  initiator <-> word-addressed synchronous RAM port
//   modport master : the initiator's view (drives req_ready, rsp_*, ram_* strobes)
//   modport slave  : the surrounding pipeline/RAM view (drives requests, rsp_ready, ram_dout)
interface gac_mem_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_we;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        ram_cs;
    logic        ram_oe;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_dout,
        output req_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err,
               ram_cs, ram_oe, ram_we, ram_addr, ram_din
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_dout,
        input  req_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err,
               ram_cs, ram_oe, ram_we, ram_addr, ram_din
    );
endinterface

// File: rtl/gac_mem_initiator.sv
// gac_mem_initiator
//   Request-side master for a word-addressed synchronous RAM. Load/store
//   requests are queued in a small FIFO and executed one at a time; each
//   request produces exactly one response, in request order. Misaligned
//   addresses are answered with rsp_err=1 without touching the RAM.
// Parameters
//   FIFO_DEPTH  request queue entries (power of 2, >=2)
//   RD_LAT      cycles waited after the RAM strobe cycle before ram_dout is captured (>=1)
// Ports
//   clk    clock, posedge
//   rst_n  synchronous reset, active low
//   bus    gac_mem_initiator_if.master (req_*, rsp_*, ram_* groups)
//   busy   FSM not idle or request queue non-empty
module gac_mem_initiator #(
    parameter int FIFO_DEPTH = 2,
    parameter int RD_LAT     = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    gac_mem_initiator_if.master        bus,
    output logic                       busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    // Request queue
    logic              r_fifo_we    [FIFO_DEPTH];
    logic [31:0]       r_fifo_addr  [FIFO_DEPTH];
    logic [31:0]       r_fifo_wdata [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;

    logic              w_ready;
    logic              w_push;
    logic              w_pop;
    logic              w_head_we;
    logic [31:0]       w_head_addr;
    logic [31:0]       w_head_wdata;

    // Sequencer state and registered outputs
    state_t            r_state;
    logic              r_cur_we;
    logic [CNT_W-1:0]  r_lat_cnt;
    logic              r_ram_cs;
    logic              r_ram_oe;
    logic              r_ram_we;
    logic [31:0]       r_ram_addr;
    logic [31:0]       r_ram_din;
    logic              r_rsp_valid;
    logic              r_rsp_we;
    logic [31:0]       r_rsp_rdata;
    logic              r_rsp_err;

    // req_ready looks only at occupancy, so a same-cycle pop never opens a slot early.
    assign w_ready      = (r_count != (PTR_W+1)'(FIFO_DEPTH));
    assign w_push       = bus.req_valid & w_ready;
    assign w_pop        = (r_state == IDLE) && (r_count != '0);
    assign w_head_we    = r_fifo_we[r_rd_ptr];
    assign w_head_addr  = r_fifo_addr[r_rd_ptr];
    assign w_head_wdata = r_fifo_wdata[r_rd_ptr];

    // Queue payload needs no reset: entries are only read when the count says they are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_we[r_wr_ptr]    <= bus.req_we;
            r_fifo_addr[r_wr_ptr]  <= bus.req_addr;
            r_fifo_wdata[r_wr_ptr] <= bus.req_wdata;
        end
    end

    // Power-of-2 depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cur_we    <= 1'b0;
            r_lat_cnt   <= '0;
            r_ram_cs    <= 1'b0;
            r_ram_oe    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_din   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_we    <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_cur_we <= w_head_we;
                        if (w_head_addr[1:0] != 2'b00) begin
                            // Misaligned: answer directly, RAM untouched.
                            r_rsp_valid <= 1'b1;
                            r_rsp_we    <= w_head_we;
                            r_rsp_rdata <= '0;
                            r_rsp_err   <= 1'b1;
                            r_state     <= RESP;
                        end else begin
                            r_ram_cs   <= 1'b1;
                            r_ram_we   <= w_head_we;
                            r_ram_oe   <= ~w_head_we;
                            r_ram_addr <= w_head_addr;
                            r_ram_din  <= w_head_wdata;
                            r_state    <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    // Single-cycle strobe; address/data keep their last value.
                    r_ram_cs <= 1'b0;
                    r_ram_oe <= 1'b0;
                    r_ram_we <= 1'b0;
                    if (r_cur_we) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_we    <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b0;
                        r_state     <= RESP;
                    end else begin
                        r_lat_cnt <= CNT_W'(RD_LAT);
                        r_state   <= WAIT;
                    end
                end
                WAIT: begin
                    r_lat_cnt <= r_lat_cnt - CNT_W'(1);
                    if (r_lat_cnt == CNT_W'(1)) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_we    <= 1'b0;
                        r_rsp_rdata <= bus.ram_dout;
                        r_rsp_err   <= 1'b0;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_we    = r_rsp_we;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.ram_cs    = r_ram_cs;
    assign bus.ram_oe    = r_ram_oe;
    assign bus.ram_we    = r_ram_we;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_din   = r_ram_din;
    assign busy          = (r_state != IDLE) || (r_count != '0);
endmodule

// File: tb/tb_gac_mem_initiator.sv
module tb_gac_mem_initiator;
    logic clk;
    logic rst_n;
    logic busy0;
    logic busy1;

    gac_mem_initiator_if if0 ();
    gac_mem_initiator_if if1 ();

    gac_mem_initiator #(.FIFO_DEPTH(2), .RD_LAT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.master), .busy(busy0));
    gac_mem_initiator #(.FIFO_DEPTH(2), .RD_LAT(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.master), .busy(busy1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cs0   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Synchronous RAM models: write/read at the edge that ends the strobe cycle.
    bit [31:0] ram0 [256];
    bit [31:0] ram1 [256];
    always @(posedge clk) begin
        if (if0.ram_cs) begin
            if (if0.ram_we) ram0[if0.ram_addr[9:2]] <= if0.ram_din;
            if (if0.ram_oe) if0.ram_dout <= ram0[if0.ram_addr[9:2]];
        end
        if (if1.ram_cs) begin
            if (if1.ram_we) ram1[if1.ram_addr[9:2]] <= if1.ram_din;
            if (if1.ram_oe) if1.ram_dout <= ram1[if1.ram_addr[9:2]];
        end
    end

    // Reference model for instance 0: every accepted request yields one response
    // in order; aligned ones yield one strobe; loads return the last stored word.
    typedef struct packed { logic we; logic [31:0] rdata; logic err; } rsp_t;
    typedef struct packed { logic we; logic [31:0] addr; logic [31:0] din; } stb_t;
    rsp_t      exp_rsp [$];
    stb_t      exp_stb [$];
    bit [31:0] refmem  [256];
    logic        hold_q;
    logic        h_we;
    logic [31:0] h_rdata;
    logic        h_err;
    logic        prev_cs;

    always @(negedge clk) begin
        rsp_t e;
        stb_t s;
        if (!rst_n) begin
            exp_rsp.delete();
            exp_stb.delete();
            hold_q  = 1'b0;
            prev_cs = 1'b0;
        end else begin
            check("busy", busy0, exp_rsp.size() != 0);
            if (hold_q) begin
                check("rsp_hold_valid", if0.rsp_valid, 1'b1);
                check("rsp_hold_we", if0.rsp_we, h_we);
                check("rsp_hold_rdata", if0.rsp_rdata, h_rdata);
                check("rsp_hold_err", if0.rsp_err, h_err);
            end
            if (if0.rsp_valid && if0.rsp_ready) begin
                if (exp_rsp.size() == 0) check("rsp_unexpected", 1'b1, 1'b0);
                else begin
                    e = exp_rsp.pop_front();
                    check("rsp_we", if0.rsp_we, e.we);
                    check("rsp_rdata", if0.rsp_rdata, e.rdata);
                    check("rsp_err", if0.rsp_err, e.err);
                end
            end
            hold_q  = if0.rsp_valid && !if0.rsp_ready;
            h_we    = if0.rsp_we;
            h_rdata = if0.rsp_rdata;
            h_err   = if0.rsp_err;
            if (if0.ram_cs) begin
                cs0++;
                check("cs_single_pulse", prev_cs, 1'b0);
                if (exp_stb.size() == 0) check("strobe_unexpected", 1'b1, 1'b0);
                else begin
                    s = exp_stb.pop_front();
                    check("ram_we", if0.ram_we, s.we);
                    check("ram_oe", if0.ram_oe, !s.we);
                    check("ram_addr", if0.ram_addr, s.addr);
                    check("ram_din", if0.ram_din, s.din);
                end
            end else begin
                check("ram_we_idle", if0.ram_we, 1'b0);
                check("ram_oe_idle", if0.ram_oe, 1'b0);
            end
            prev_cs = if0.ram_cs;
            if (if0.req_valid && if0.req_ready) begin
                if (if0.req_addr[1:0] != 2'b00)
                    exp_rsp.push_back('{if0.req_we, 32'h0, 1'b1});
                else if (if0.req_we) begin
                    refmem[if0.req_addr[9:2]] = if0.req_wdata;
                    exp_rsp.push_back('{1'b1, 32'h0, 1'b0});
                    exp_stb.push_back('{1'b1, if0.req_addr, if0.req_wdata});
                end else begin
                    exp_rsp.push_back('{1'b0, refmem[if0.req_addr[9:2]], 1'b0});
                    exp_stb.push_back('{1'b0, if0.req_addr, if0.req_wdata});
                end
            end
        end
    end

    function automatic logic rv(input int inst);
        return (inst == 0) ? if0.rsp_valid : if1.rsp_valid;
    endfunction

    task automatic set_req(input int inst, input logic v, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
        if (inst == 0) begin
            if0.req_valid = v; if0.req_we = we; if0.req_addr = addr; if0.req_wdata = wdata;
        end else begin
            if1.req_valid = v; if1.req_we = we; if1.req_addr = addr; if1.req_wdata = wdata;
        end
    endtask

    // Called #1 after a posedge with the DUT idle and rsp_ready=1. lat counts
    // cycles from the acceptance cycle to the first cycle with rsp_valid=1.
    task automatic do_req(input int inst, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output logic rwe,
                          output logic [31:0] rdata, output logic rerr);
        set_req(inst, 1'b1, we, addr, wdata);
        @(posedge clk); #1;
        set_req(inst, 1'b0, 1'b0, 32'h0, 32'h0);
        lat = 1;
        while (!rv(inst) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!rv(inst)) check("rsp_timeout", 1'b0, 1'b1);
        rwe   = (inst == 0) ? if0.rsp_we    : if1.rsp_we;
        rdata = (inst == 0) ? if0.rsp_rdata : if1.rsp_rdata;
        rerr  = (inst == 0) ? if0.rsp_err   : if1.rsp_err;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic        rwe;
        logic [31:0] rdata;
        logic        rerr;
        int          p;
        int          t;

        rst_n = 1'b0;
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        if0.rsp_ready = 1'b1;
        if1.rsp_ready = 1'b1;

        // 1: reset
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_req_ready", if0.req_ready, 1'b1);
        check("rst_rsp_valid", if0.rsp_valid, 1'b0);
        check("rst_ram_cs", if0.ram_cs, 1'b0);
        check("rst_busy", busy0, 1'b0);
        check("rst_req_ready1", if1.req_ready, 1'b1);
        check("rst_busy1", busy1, 1'b0);

        // 2: store then load of the same word
        p = cs0;
        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, lat, rwe, rdata, rerr);
        check("st_lat", lat, 3);
        check("st_we", rwe, 1'b1);
        check("st_rdata", rdata, 32'h0);
        check("st_err", rerr, 1'b0);
        do_req(0, 1'b0, 32'h10, 32'h0, lat, rwe, rdata, rerr);
        check("ld_lat", lat, 4);
        check("ld_rdata", rdata, 32'hDEADBEEF);
        check("ld_err", rerr, 1'b0);
        check("st_ld_cs_pulses", cs0 - p, 2);

        // 3: misaligned load
        p = cs0;
        do_req(0, 1'b0, 32'h13, 32'h0, lat, rwe, rdata, rerr);
        check("mis_lat", lat, 2);
        check("mis_err", rerr, 1'b1);
        check("mis_rdata", rdata, 32'h0);
        check("mis_cs_pulses", cs0 - p, 0);

        // 4: three back-to-back requests while responses are stalled
        if0.rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bb_ready_before_push", if0.req_ready, 1'b1);
            case (i)
                0:       set_req(0, 1'b1, 1'b1, 32'h40, 32'h11);
                1:       set_req(0, 1'b1, 1'b1, 32'h44, 32'h22);
                default: set_req(0, 1'b1, 1'b0, 32'h40, 32'h0);
            endcase
            @(posedge clk); #1;
        end
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("bb_full_ready", if0.req_ready, 1'b0);
        check("bb_busy", busy0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("bb_still_full", if0.req_ready, 1'b0);
        if0.rsp_ready = 1'b1;
        t = 0;
        while (busy0 && t < 60) begin
            @(posedge clk); #1;
            t++;
        end
        check("bb_drained", busy0, 1'b0);
        check("bb_all_rsp", exp_rsp.size(), 0);
        check("bb_ram_word", ram0[32'h44 >> 2], 32'h22);

        // 5: reset during WAIT of a load
        set_req(0, 1'b1, 1'b0, 32'h44, 32'h0);
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        check("rw_issue_cs", if0.ram_cs, 1'b1);
        @(posedge clk); #1;
        check("rw_wait_no_rsp", if0.rsp_valid, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("rw_dropped_rsp", if0.rsp_valid, 1'b0);
            @(posedge clk); #1;
        end
        check("rw_idle", busy0, 1'b0);
        do_req(0, 1'b1, 32'h48, 32'hCAFEF00D, lat, rwe, rdata, rerr);
        check("rw_st_lat", lat, 3);
        do_req(0, 1'b0, 32'h48, 32'h0, lat, rwe, rdata, rerr);
        check("rw_ld_lat", lat, 4);
        check("rw_ld_rdata", rdata, 32'hCAFEF00D);

        // 6: RD_LAT=3 instance
        do_req(1, 1'b1, 32'h20, 32'h12345678, lat, rwe, rdata, rerr);
        check("rl3_st_lat", lat, 3);
        do_req(1, 1'b0, 32'h20, 32'h0, lat, rwe, rdata, rerr);
        check("rl3_ld_lat", lat, 6);
        check("rl3_ld_rdata", rdata, 32'h12345678);
        check("rl3_ld_err", rerr, 1'b0);
        check("rl3_rsp_dropped", if1.rsp_valid, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
